// File: rtl/tel_caller_driver.sv
// rtl/tel_caller_driver.sv - caller-side character transmitter for the telephone FSM
//
// Buffers host characters in a FIFO, places a call, waits for the answer and
// streams the buffered characters one per cycle to the phone block. Yields
// the turn on DEL (127), hangs up on request and waits out the cost display.
//
// Optional build macro: TEL_CHAR_FILTER_EN
//   defined   - pushed bytes outside 32..127 complete the handshake but are dropped
//   undefined - every byte is stored and sent verbatim
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   dial           in   place a call (honoured only in IDLE)
//   hangup_req     in   end the call once the FIFO drains (latched until IDLE)
//   in_valid       in   host character valid
//   in_char        in   host character [7:0]
//   in_ready       out  FIFO not full
//   statusMsg      in   8-char ASCII phone status [63:0]
//   startCall      out  one-cycle pulse while dialling
//   endCallCaller  out  one-cycle pulse while hanging up
//   sendCharCaller out  character strobe
//   charSent       out  character [7:0], zero when not strobed
//   busy           out  state is not IDLE
//   call_failed    out  one-cycle pulse on rejection or answer timeout
//   fifo_count     out  FIFO occupancy [clog2(DEPTH):0]

module tel_caller_driver #(
    parameter int DEPTH          = 8,
    parameter int ANSWER_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dial,
    input  logic                     hangup_req,
    input  logic                     in_valid,
    input  logic [7:0]               in_char,
    output logic                     in_ready,
    input  logic [63:0]              statusMsg,
    output logic                     startCall,
    output logic                     endCallCaller,
    output logic                     sendCharCaller,
    output logic [7:0]               charSent,
    output logic                     busy,
    output logic                     call_failed,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ANSWER_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DIAL      = 3'd1;
    localparam logic [2:0] S_WAIT_ANS  = 3'd2;
    localparam logic [2:0] S_FAIL      = 3'd3;
    localparam logic [2:0] S_TALK      = 3'd4;
    localparam logic [2:0] S_YIELD     = 3'd5;
    localparam logic [2:0] S_HANGUP    = 3'd6;
    localparam logic [2:0] S_WAIT_COST = 3'd7;

    localparam logic [63:0] MSG_IDLE     = "IDLE    ";
    localparam logic [63:0] MSG_RINGING  = "RINGING ";
    localparam logic [63:0] MSG_REJECTED = "REJECTED";
    localparam logic [63:0] MSG_CALLER   = "CALLER  ";
    localparam logic [63:0] MSG_CALLEE   = "CALLEE  ";
    localparam logic [63:0] MSG_COST     = "COST    ";

    logic [2:0]    state, state_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic          ringing_seen;
    logic          hangup_latched;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          full, empty, push, store, pop, flush;
    logic [7:0]    head;

    logic is_idle, is_ringing, is_rejected, is_caller, is_callee, is_cost, remote_end;

    assign is_idle     = (statusMsg == MSG_IDLE);
    assign is_ringing  = (statusMsg == MSG_RINGING);
    assign is_rejected = (statusMsg == MSG_REJECTED);
    assign is_caller   = (statusMsg == MSG_CALLER);
    assign is_callee   = (statusMsg == MSG_CALLEE);
    assign is_cost     = (statusMsg == MSG_COST);
    assign remote_end  = is_cost || is_idle;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != S_IDLE);
    assign timer_inc  = timer + TW'(1);

`ifdef TEL_CHAR_FILTER_EN
    // Non-printable bytes still complete the handshake so the host never stalls on them.
    assign store = push && (in_char >= 8'd32) && !in_char[7];
`else
    assign store = push;
`endif

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state)
            S_IDLE: begin
                if (dial) state_n = S_DIAL;
            end
            S_DIAL: begin
                state_n = S_WAIT_ANS;
            end
            S_WAIT_ANS: begin
                // timer_inc is the number of WAIT_ANS cycles including this one.
                if (is_caller) begin
                    state_n = S_TALK;
                end else if (is_rejected || (timer_inc == TW'(ANSWER_TIMEOUT)) ||
                             (is_idle && ringing_seen)) begin
                    state_n = S_FAIL;
                    flush   = 1'b1;
                end
            end
            S_FAIL: begin
                state_n = S_IDLE;
            end
            S_TALK: begin
                if (remote_end) begin
                    flush   = 1'b1;
                    state_n = S_WAIT_COST;
                end else if (!empty && is_caller) begin
                    pop = 1'b1;
                    if (head == 8'd127) state_n = S_YIELD;
                end else if (empty && hangup_latched) begin
                    state_n = S_HANGUP;
                end
            end
            S_YIELD: begin
                if (remote_end) begin
                    flush   = 1'b1;
                    state_n = S_WAIT_COST;
                end else if (is_callee) begin
                    state_n = S_TALK;
                end
            end
            S_HANGUP: begin
                state_n = S_WAIT_COST;
            end
            S_WAIT_COST: begin
                if (is_idle) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            timer          <= '0;
            ringing_seen   <= 1'b0;
            hangup_latched <= 1'b0;
            startCall      <= 1'b0;
            endCallCaller  <= 1'b0;
            sendCharCaller <= 1'b0;
            charSent       <= 8'd0;
            call_failed    <= 1'b0;
        end else begin
            state <= state_n;

            if (state == S_DIAL) begin
                timer        <= '0;
                ringing_seen <= 1'b0;
            end else if (state == S_WAIT_ANS) begin
                timer <= timer_inc;
                if (is_ringing) ringing_seen <= 1'b1;
            end

            if (state != S_IDLE && state_n == S_IDLE)
                hangup_latched <= 1'b0;
            else if (hangup_req && state != S_IDLE)
                hangup_latched <= 1'b1;

            // Outputs are registered on the transition so each pulse lines up
            // with the cycle spent in the corresponding state.
            startCall      <= (state == S_IDLE) && dial;
            call_failed    <= (state == S_WAIT_ANS) && (state_n == S_FAIL);
            endCallCaller  <= (state == S_TALK) && (state_n == S_HANGUP);
            sendCharCaller <= pop;
            charSent       <= pop ? head : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= in_char;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (flush) begin
                // Discard the old contents but keep a byte written this same cycle.
                rd_ptr <= wr_ptr;
                count  <= store ? CW'(1) : '0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                case ({store, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tel_caller_driver.sv
// tb/tb_tel_caller_driver.sv - scoreboard bench for tel_caller_driver

module tb_tel_caller_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dial = 1'b0;
    logic        hangup_req = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'd0;
    logic        in_ready;
    logic [63:0] statusMsg = "IDLE    ";
    logic        startCall, endCallCaller, sendCharCaller, busy, call_failed;
    logic [7:0]  charSent;
    logic [3:0]  fifo_count;

    tel_caller_driver #(.DEPTH(8), .ANSWER_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .dial(dial), .hangup_req(hangup_req),
        .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
        .statusMsg(statusMsg), .startCall(startCall), .endCallCaller(endCallCaller),
        .sendCharCaller(sendCharCaller), .charSent(charSent), .busy(busy),
        .call_failed(call_failed), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    bit sb_on = 1'b1;
    int send_total = 0, end_total = 0, fail_total = 0;
    int last_send_cyc = 0, prev_send_cyc = 0, last_end_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (sendCharCaller) begin
                send_total++;
                prev_send_cyc = last_send_cyc;
                last_send_cyc = cyc;
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_send: actual=%0h required=none", charSent);
                    end else begin
                        chk("charSent", charSent, exp_q.pop_front());
                    end
                end
            end else begin
                chk("charSent_idle_zero", charSent, 0);
            end
            if (sendCharCaller && endCallCaller) begin
                total++;
                bad++;
                $display("FAIL send_and_end_same_cycle: actual=1 required=0");
            end
            if (endCallCaller) begin
                end_total++;
                last_end_cyc = cyc;
            end
            if (call_failed) fail_total++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input bit expect_send);
        in_valid = 1'b1;
        in_char  = c;
        if (expect_send) exp_q.push_back(c);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic do_dial();
        dial = 1'b1;
        step(1);
        dial = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int s0, e0, f0, k;

    initial begin
        step(3);
        chk("rst_startCall", startCall, 0);
        chk("rst_endCallCaller", endCallCaller, 0);
        chk("rst_sendCharCaller", sendCharCaller, 0);
        chk("rst_charSent", charSent, 0);
        chk("rst_busy", busy, 0);
        chk("rst_call_failed", call_failed, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        step(1);

        // "HI" sent back-to-back once the callee answers
        push(8'h48, 1'b1);
        push(8'h49, 1'b1);
        chk("hi_count", fifo_count, 2);
        s0 = send_total;
        e0 = end_total;
        do_dial();
        chk("dial_startCall", startCall, 1);
        chk("dial_busy", busy, 1);
        statusMsg = "RINGING ";
        step(2);
        chk("ringing_no_send", sendCharCaller, 0);
        statusMsg = "CALLER  ";
        step(4);
        chk("hi_sends", send_total - s0, 2);
        chk("hi_back_to_back", last_send_cyc - prev_send_cyc, 1);
        chk("hi_drained", fifo_count, 0);
        statusMsg = "COST    ";
        step(2);
        chk("remote_cost_busy", busy, 1);
        statusMsg = "IDLE    ";
        step(2);
        chk("remote_idle_busy", busy, 0);
        chk("remote_no_hangup", end_total - e0, 0);

        // fill to DEPTH, then a refused ninth push
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 1'b0);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", fifo_count, 8);
        push(8'h70, 1'b0);
        chk("ninth_count", fifo_count, 8);

        // rejection flushes the FIFO
        f0 = fail_total;
        do_dial();
        statusMsg = "REJECTED";
        step(2);
        chk("rej_call_failed", call_failed, 1);
        chk("rej_flushed", fifo_count, 0);
        step(1);
        chk("rej_busy", busy, 0);
        chk("rej_pulse_once", fail_total - f0, 1);
        chk("rej_in_ready", in_ready, 1);

        // answer timeout: DIAL cycle, 16 WAIT_ANS cycles, then FAIL
        statusMsg = "RINGING ";
        do_dial();
        chk("to_startCall", startCall, 1);
        k = 0;
        while (!call_failed && k < 40) begin
            step(1);
            k++;
        end
        chk("timeout_cycles", k, 17);
        step(1);
        chk("timeout_busy", busy, 0);
        statusMsg = "IDLE    ";
        step(1);

        // DEL yields the turn; 0x42 waits for CALLEE then CALLER
        do_dial();
        statusMsg = "CALLER  ";
        step(2);
        chk("talk_busy", busy, 1);
        s0 = send_total;
        push(8'h41, 1'b1);
        push(8'h7F, 1'b1);
        push(8'h42, 1'b1);
        step(3);
        chk("yield_sends", send_total - s0, 2);
        chk("yield_held", fifo_count, 1);
        statusMsg = "CALLEE  ";
        step(2);
        chk("callee_held", fifo_count, 1);
        chk("callee_sends", send_total - s0, 2);
        statusMsg = "CALLER  ";
        step(3);
        chk("resume_drained", fifo_count, 0);
        chk("resume_sends", send_total - s0, 3);

        // "5" then hangup: endCallCaller the cycle after the last send
        e0 = end_total;
        push(8'h35, 1'b1);
        hangup_req = 1'b1;
        step(1);
        hangup_req = 1'b0;
        step(3);
        chk("hangup_pulses", end_total - e0, 1);
        chk("hangup_after_send", last_end_cyc - last_send_cyc, 1);
        chk("hangup_busy", busy, 1);
        statusMsg = "COST    ";
        step(3);
        chk("cost_busy", busy, 1);
        statusMsg = "IDLE    ";
        step(2);
        chk("cost_done_busy", busy, 0);

        // hangup latch cleared: an empty TALK does not hang up; then reset mid-TALK
        e0 = end_total;
        do_dial();
        statusMsg = "CALLER  ";
        step(5);
        chk("latch_cleared", end_total - e0, 0);
        chk("latch_busy", busy, 1);
        sb_on = 1'b0;
        push(8'h31, 1'b0);
        push(8'h32, 1'b0);
        push(8'h33, 1'b0);
        chk("pre_reset_send", sendCharCaller, 1);
        rst = 1'b0;
        #1;
        chk("async_sendCharCaller", sendCharCaller, 0);
        chk("async_charSent", charSent, 0);
        chk("async_busy", busy, 0);
        chk("async_fifo_count", fifo_count, 0);
        chk("async_in_ready", in_ready, 1);
        step(1);
        rst = 1'b1;
        statusMsg = "IDLE    ";
        step(1);
        sb_on = 1'b1;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tel_caller_driver.md
Name: tel_caller_driver

Overview:
Caller-side transmitter for the telephone FSM. It buffers host characters in a FIFO, places a call, waits for the phone to answer, and streams the buffered characters one per cycle on the caller send interface. It also yields the turn on DEL (127), hangs up on request, and waits for the cost display to finish. It sits between a host or testbench byte source and the phone block: it drives startCall, endCallCaller, sendCharCaller and charSent, and watches statusMsg.

Parameters:
DEPTH, 8, FIFO depth in characters; power of 2, minimum 2.
ANSWER_TIMEOUT, 16, maximum cycles spent in WAIT_ANS before declaring failure.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
dial  input  1  request to place a call; honoured only in IDLE
hangup_req  input  1  request to end the call once the FIFO drains; sticky until return to IDLE
in_valid  input  1  host character valid
in_char  input  8  host character
in_ready  output  1  FIFO can accept; equals !full, combinational from count
statusMsg  input  64  8-char ASCII phone status ("IDLE    ", "RINGING ", "REJECTED", "CALLER  ", "CALLEE  ", "COST    ")
startCall  output  1  one-cycle pulse, registered
endCallCaller  output  1  one-cycle pulse, registered
sendCharCaller  output  1  character strobe, registered
charSent  output  8  character, registered; 0 when sendCharCaller=0
busy  output  1  1 whenever state != IDLE
call_failed  output  1  one-cycle pulse on rejection or timeout
fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs 0 except in_ready=1; FIFO empty; hangup latch clear; timer 0; state IDLE.
- FIFO push: occurs when in_valid & in_ready. Pop only in TALK as described below. Simultaneous push and pop leaves the count unchanged. Pushes are accepted in every state.
- FIFO has no bypass: a character pushed in cycle n can be sent at the earliest in cycle n+2.
- Pointers wrap modulo DEPTH.
- States:
  - IDLE: dial=1 -> DIAL.
  - DIAL: startCall=1 for exactly this one cycle; timer cleared -> WAIT_ANS.
  - WAIT_ANS: timer increments each cycle.
    - statusMsg=="CALLER  " -> TALK.
    - statusMsg=="REJECTED", or timer==ANSWER_TIMEOUT -> FAIL.
    - statusMsg=="IDLE    " after "RINGING " has been seen -> FAIL.
  - FAIL: call_failed=1 for one cycle; FIFO flushed -> IDLE.
  - TALK:
    - statusMsg=="COST    " or "IDLE    " (remote end) -> flush FIFO -> WAIT_COST.
    - Otherwise, if FIFO non-empty and statusMsg=="CALLER  ": pop the head; next cycle sendCharCaller=1 and charSent=head.
    - If the popped char is 127 -> YIELD.
    - If FIFO empty and hangup latched -> HANGUP.
  - YIELD: no sends; wait for statusMsg=="CALLEE  ", then return to TALK. Remote end -> flush FIFO -> WAIT_COST.
  - HANGUP: endCallCaller=1 for one cycle -> WAIT_COST.
  - WAIT_COST: wait for statusMsg=="IDLE    " -> IDLE; clear the hangup latch on this exit.
- Throughput: one character per cycle in TALK while statusMsg stays "CALLER  ".
- sendCharCaller and endCallCaller are never asserted in the same cycle.
- dial outside IDLE is ignored. hangup_req in IDLE is ignored.
- Reset mid-call: outputs drop immediately and asynchronously; buffered characters are lost.

Optional Feature:
TEL_CHAR_FILTER_EN
- Defined: pushed characters outside 32..127 are accepted (in_ready handshake completes) but discarded; fifo_count does not change.
- Undefined: every byte is stored and sent verbatim.

Test Plan:
- Push "HI" (0x48, 0x49); pulse dial; phone answers, statusMsg "RINGING " -> "CALLER  " -> exactly two cycles with sendCharCaller=1, charSent 0x48 then 0x49, back-to-back.
- Fill FIFO with 8 chars while IDLE -> in_ready=0 and fifo_count=8. A 9th push with in_valid=1 is not accepted; fifo_count stays 8.
- Dial, phone goes "REJECTED" -> call_failed pulses once; FIFO flushed (fifo_count=0); back to IDLE with busy=0.
- Dial, statusMsg held at "RINGING " -> after 16 cycles in WAIT_ANS, call_failed=1 and state IDLE.
- In call, push 0x41, 0x7F, 0x42 -> 0x41 and 0x7F are sent; 0x42 is held until statusMsg goes "CALLEE  " then "CALLER  ", then sent.
- Push "5" then assert hangup_req -> 0x35 is sent, endCallCaller pulses the next eligible cycle, and the driver waits through "COST    " until "IDLE    " before busy drops. Also: pull rst low mid-TALK -> all outputs go 0 immediately.
